// File: rtl/keypad_scan.sv
// ============================================================================
//  Module      : keypad_scan
//  Description : 4x3 matrix keypad scanner with debounce. Drives one column
//                at a time, collects row hits over a full scan, and turns
//                stable single-key scans into one-cycle key strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan #(
    parameter int COL_CYCLES     = 2,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int          c_slot_w    = $clog2(COL_CYCLES) + 1;
    localparam int          c_cnt_w     = $clog2(DEBOUNCE_SCANS) + 1;
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(COL_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]  c_deb       = c_cnt_w'(DEBOUNCE_SCANS);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [3:0]  c_none      = 4'hF;
    localparam logic [3:0]  c_multi     = 4'hE;   // internal only, never output

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAND = 2'd1,
        S_HELD = 2'd2,
        S_REL  = 2'd3
    } state_t;

    // Key code for hit-vector position row*3+col.
    function automatic logic [3:0] f_key_code(input int idx);
        case (idx)
            0:  f_key_code = 4'd1;
            1:  f_key_code = 4'd2;
            2:  f_key_code = 4'd3;
            3:  f_key_code = 4'd4;
            4:  f_key_code = 4'd5;
            5:  f_key_code = 4'd6;
            6:  f_key_code = 4'd7;
            7:  f_key_code = 4'd8;
            8:  f_key_code = 4'd9;
            9:  f_key_code = 4'd10;
            10: f_key_code = 4'd0;
            11: f_key_code = 4'd11;
            default: f_key_code = c_none;
        endcase
    endfunction

    logic [c_slot_w-1:0] r_slot_cnt;
    logic [2:0]          r_col_oh;
    logic                w_slot_last;
    logic [3:0]          r_row_meta, r_row_sync;
    logic [3:0]          r_tag1, r_tag2;      // {slot_last, column one-hot}
    logic                w_sample, w_scan_end;
    logic [2:0]          w_col;
    logic [11:0]         r_hits, w_hits;
    logic [1:0]          w_n_hits;
    logic [3:0]          w_hit_code, w_result;
    logic                w_single;

    state_t              r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [c_cnt_w-1:0]  r_rcnt, w_rcnt_nxt, w_rcnt_inc;
    logic [3:0]          r_cand, w_cand_nxt;
    logic [3:0]          r_key_code, w_code_nxt;
    logic                r_key_valid, w_valid_nxt;
    logic                r_key_down, w_down_nxt;

    assign w_slot_last = (r_slot_cnt == c_slot_last);

    // Column slot timer and one-hot column rotation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_cnt <= '0;
            r_col_oh   <= 3'b001;
        end else if (w_slot_last) begin
            r_slot_cnt <= '0;
            r_col_oh   <= {r_col_oh[1:0], r_col_oh[2]};
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // Two-flop row synchroniser; the slot tag travels alongside so each
    // synchronised row sample stays paired with the column that produced it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_meta <= '0;
            r_row_sync <= '0;
            r_tag1     <= '0;
            r_tag2     <= '0;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
            r_tag1     <= {w_slot_last, r_col_oh};
            r_tag2     <= r_tag1;
        end
    end

    assign w_sample   = r_tag2[3];
    assign w_col      = r_tag2[2:0];
    assign w_scan_end = w_sample & w_col[2];

    // Merge the rows sampled at the end of a column slot into the hit vector.
    always_comb begin
        w_hits = r_hits;
        if (w_sample) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                    if (r_row_sync[r] && w_col[c]) begin
                        w_hits[r*3 + c] = 1'b1;
                    end
                end
            end
        end
    end

    // Hit vector accumulates across one full scan, cleared when the scan closes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hits <= '0;
        end else if (w_scan_end) begin
            r_hits <= '0;
        end else begin
            r_hits <= w_hits;
        end
    end

    // Reduce the hit vector to a single code, NONE or MULTI.
    always_comb begin
        w_n_hits   = 2'd0;
        w_hit_code = c_none;
        for (int i = 0; i < 12; i++) begin
            if (w_hits[i]) begin
                w_hit_code = f_key_code(i);
                if (w_n_hits != 2'd2) begin
                    w_n_hits = w_n_hits + 2'd1;
                end
            end
        end
        if (w_n_hits == 2'd0) begin
            w_result = c_none;
        end else if (w_n_hits == 2'd1) begin
            w_result = w_hit_code;
        end else begin
            w_result = c_multi;
        end
        w_single = (w_n_hits == 2'd1);
    end

    assign w_cnt_inc  = (r_cnt  >= c_deb) ? r_cnt  : r_cnt  + c_cnt_one;
    assign w_rcnt_inc = (r_rcnt >= c_deb) ? r_rcnt : r_rcnt + c_cnt_one;

    // Debounce FSM next-state logic, evaluated once per completed scan.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rcnt_nxt  = r_rcnt;
        w_cand_nxt  = r_cand;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        w_down_nxt  = r_key_down;
        if (w_scan_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_result;
                        if (c_deb == c_cnt_one) begin
                            w_code_nxt  = w_result;
                            w_valid_nxt = 1'b1;
                            w_down_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_cnt_nxt   = c_cnt_one;
                            w_state_nxt = S_CAND;
                        end
                    end
                end
                S_CAND: begin
                    if (w_single && (w_result == r_cand)) begin
                        if (w_cnt_inc >= c_deb) begin
                            w_code_nxt  = r_cand;
                            w_valid_nxt = 1'b1;
                            w_down_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else if (w_single) begin
                        w_cand_nxt = w_result;
                        w_cnt_nxt  = c_cnt_one;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (w_result == c_none) begin
                        if (c_deb == c_cnt_one) begin
                            w_down_nxt  = 1'b0;
                            w_rcnt_nxt  = '0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_rcnt_nxt  = c_cnt_one;
                            w_state_nxt = S_REL;
                        end
                    end
                end
                S_REL: begin
                    if (w_result == c_none) begin
                        if (w_rcnt_inc >= c_deb) begin
                            w_down_nxt  = 1'b0;
                            w_rcnt_nxt  = '0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_rcnt_nxt = w_rcnt_inc;
                        end
                    end else begin
                        w_rcnt_nxt  = '0;
                        w_state_nxt = S_HELD;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Debounce counters, candidate and registered key outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_rcnt      <= '0;
            r_cand      <= c_none;
            r_key_code  <= c_none;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_rcnt      <= w_rcnt_nxt;
            r_cand      <= w_cand_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_down  <= w_down_nxt;
        end
    end

    assign col_out   = r_col_oh;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_down  = r_key_down;

endmodule

`default_nettype wire

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
Upstream front-end for the watch time-setting path. Scans a 4-row x 3-column matrix keypad and debounces the result. Emits one-cycle strobes with a 4-bit key code, which the watch block consumes as its keypad digit input. Runs on the same 1 kHz system clock as the watch.

Parameters:
COL_CYCLES, 2, clock cycles each column is driven; rows are sampled on the last cycle of the slot (min 2).
DEBOUNCE_SCANS, 3, consecutive identical full-scan results required to accept a press or a release (min 1).

Ports:
clk  input  1  system clock, 1 kHz
rst  input  1  asynchronous, active-low reset
row_in  input  4  keypad rows, active-high (external pull-downs), asynchronous to clk
col_out  output  3  column drive, one-hot active-high
key_code  output  4  code of the accepted key; 0-9 digits, 10 = '*', 11 = '#', 15 = none
key_valid  output  1  one-cycle strobe when a new debounced press is accepted
key_down  output  1  level, high from the acceptance strobe until the debounced release

Behaviour:
- Reset (rst low, asynchronous): col_out=3'b001, key_code=4'hF, key_valid=0, key_down=0, all counters 0, FSM in IDLE.
- Row synchroniser: 2-flop synchroniser on row_in. Only synchronised rows are used.
- Scanner:
  - Column index cycles 0,1,2,0,... and each column is held COL_CYCLES cycles. Full scan = 3*COL_CYCLES cycles (6 by default).
  - On the last cycle of each column slot, the synchronised rows are ORed into a 12-bit hit vector.
  - At the end of the column 2 slot, the scan result is formed and the hit vector is cleared.
- Key layout (row, col):
  - r0 = 1,2,3
  - r1 = 4,5,6
  - r2 = 7,8,9
  - r3 = *,0,#
- Scan result:
  - Exactly one hit: that code.
  - Zero hits: NONE.
  - Two or more hits: MULTI, an internal value that is never output.
- FSM, evaluated once per scan result:
  - IDLE: result is a single code -> CAND, cnt=1, cand=code. If DEBOUNCE_SCANS==1, go straight to the accept action.
  - CAND:
    - Same code -> cnt+1. When cnt reaches DEBOUNCE_SCANS, accept.
    - Accept means: key_code<=cand, key_valid=1 for exactly one cycle (the cycle after the scan completes), key_down<=1, go to HELD.
    - Different single code -> cand=new code, cnt=1.
    - NONE or MULTI -> IDLE, cnt=0.
  - HELD:
    - NONE -> REL, rcnt=1.
    - Any other result (including a different key or MULTI) -> stay in HELD. No strobe.
  - REL:
    - NONE -> rcnt+1. When rcnt reaches DEBOUNCE_SCANS: key_down<=0, go to IDLE.
    - Anything else -> HELD, rcnt=0.
- key_code holds the last accepted code until the next accept. It is not cleared on release.
- Only one strobe per physical press; auto-repeat is not supported.
- Latency: a clean press is accepted at the end of the DEBOUNCE_SCANS-th full scan that sees it, plus 1 cycle. With defaults this is at most 24 cycles after row_in settles, including the synchroniser and partial-scan alignment.
- Reset asserted mid-operation returns everything to reset values immediately. A key still held when reset is released is detected as a new press and produces one strobe.
- Counter widths: sized by $clog2 of the parameter +1. Counters saturate and never wrap.

Test Plan:
- Reset release, no keys: col_out sequence 001,001,010,010,100,100 repeats; key_valid never asserts; key_code=15.
- Press '5' (r1 high while col1 driven), held 60 cycles: exactly one key_valid pulse, key_code=5, within 24 cycles of press; key_down=1 until 3 clean NONE scans after release, then 0.
- Bounce: '8' toggles every 4 cycles for 20 cycles, then stays steady: exactly one pulse with key_code=8, no earlier pulse.
- '1' and '3' pressed together for 50 cycles: no pulse; key_code keeps its previous value.
- Hold '2' for 100 cycles, release for 30 cycles, press '#': two pulses total, codes 2 then 11; no pulse while '2' is held.
- Glitch on '0' shorter than 2 scans (10 cycles): no pulse. Reset pulsed while '4' is held: outputs go to reset values at once; after release, one pulse with code 4.
